int_sequencer: RTL and testbench

Multi-cycle sequencer for hardware-interrupt entry and RTI return. It sits beside the decode-stage control unit. It drives that unit's hardware-interrupt input, freezes and flushes the front end, and owns the data-memory port through a request/grant handshake while it pushes or pops PC and flags. It also commands the SP register to step, and loads PC and flags from the interrupt vector or from the stack.

---
 rtl/int_sequencer_if.sv | 31 +++
 rtl/int_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_int_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_sequencer_if.sv
// Data-memory request/grant port shared by the
// interrupt sequencer and the memory arbiter.
interface int_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt,
    output mem_rdata
  );
endinterface

// File: rtl/int_sequencer.sv
// Hardware-interrupt entry and RTI return sequencer:
// drains, pushes PC/flags, vectors, or pops them back.
module int_sequencer #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int FLAG_W          = 4,
  parameter int INT_VECTOR_ADDR = 1,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic              rti_start,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [ADDR_W-1:0] sp_in,
  int_sequencer_if.master   mem,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              hw_int_active,
  output logic              stall,
  output logic              flush,
  output logic              irq_ack,
  output logic              busy
);

  localparam int CNT_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  localparam logic [ADDR_W-1:0] VEC_ADDR =
    ADDR_W'(INT_VECTOR_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_PC,
    PUSH_FL,
    VEC,
    POP_FL,
    POP_PC,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pc_q;
  logic [FLAG_W-1:0] fl_q;
  logic              gnt;
  logic [ADDR_W-1:0] pop_addr;
  logic [DATA_W-1:0] fl_ext;

  assign gnt      = mem.mem_gnt & ~rst;
  assign pop_addr = sp_in + ADDR_W'(1);
  assign fl_ext   = {{(DATA_W-FLAG_W){1'b0}}, fl_q};

  // State, drain counter and PC/flags snapshot taken while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pc_q  <= '0;
      fl_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        pc_q <= pc_in;
        fl_q <= flags_in;
        cnt  <= DRAIN_LOAD;
      end else if (state == DRAIN) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Next state, bus request and grant-gated pulses
  always_comb begin
    state_nx      = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    sp_dec        = 1'b0;
    sp_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    flags_load    = 1'b0;
    flags_value   = '0;
    hw_int_active = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    irq_ack       = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (rti_start) begin
          state_nx = POP_FL;
        end else if (irq) begin
          state_nx = (DRAIN_CYCLES == 0) ?
                     PUSH_PC : DRAIN;
        end
      end
      DRAIN: begin
        hw_int_active = 1'b1;
        stall         = 1'b1;
        if (cnt == '0) state_nx = PUSH_PC;
      end
      PUSH_PC: begin
        hw_int_active = 1'b1;
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_in;
        mem.mem_wdata = pc_q;
        if (gnt) begin
          sp_dec   = 1'b1;
          state_nx = PUSH_FL;
        end
      end
      PUSH_FL: begin
        hw_int_active = 1'b1;
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_in;
        mem.mem_wdata = fl_ext;
        if (gnt) begin
          sp_dec   = 1'b1;
          state_nx = VEC;
        end
      end
      VEC: begin
        hw_int_active = 1'b1;
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_addr  = VEC_ADDR;
        if (gnt) begin
          pc_load       = 1'b1;
          pc_load_value = mem.mem_rdata;
          irq_ack       = 1'b1;
          state_nx      = DONE;
        end
      end
      POP_FL: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = pop_addr;
        if (gnt) begin
          sp_inc      = 1'b1;
          flags_load  = 1'b1;
          flags_value = mem.mem_rdata[FLAG_W-1:0];
          state_nx    = POP_PC;
        end
      end
      POP_PC: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = pop_addr;
        if (gnt) begin
          sp_inc        = 1'b1;
          pc_load       = 1'b1;
          pc_load_value = mem.mem_rdata;
          state_nx      = DONE;
        end
      end
      DONE: begin
        flush    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a small
// memory and SP model around the DUT.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic        rti_start;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [31:0] sp;
  logic        sp_dec;
  logic        sp_inc;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        flags_load;
  logic [3:0]  flags_value;
  logic        hw_int_active;
  logic        stall;
  logic        flush;
  logic        irq_ack;
  logic        busy;

  int_sequencer_if #(.DATA_W(32), .ADDR_W(32)) mbus ();

  int_sequencer #(
    .DATA_W(32),
    .ADDR_W(32),
    .FLAG_W(4),
    .INT_VECTOR_ADDR(1),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq(irq),
    .rti_start(rti_start),
    .pc_in(pc_in),
    .flags_in(flags_in),
    .sp_in(sp),
    .mem(mbus.master),
    .sp_dec(sp_dec),
    .sp_inc(sp_inc),
    .pc_load(pc_load),
    .pc_load_value(pc_load_value),
    .flags_load(flags_load),
    .flags_value(flags_value),
    .hw_int_active(hw_int_active),
    .stall(stall),
    .flush(flush),
    .irq_ack(irq_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wn = 0;
  logic        gnt_en;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a;
  logic [31:0] poke_d;
  logic        sp_set = 1'b0;
  logic [31:0] sp_val;
  logic        outs_or;

  assign mbus.mem_gnt   = gnt_en & mbus.mem_req;
  assign mbus.mem_rdata =
    (mbus.mem_req && !mbus.mem_we) ?
    mem[mbus.mem_addr[7:0]] : 32'h0;

  assign outs_or = |{mbus.mem_req, mbus.mem_we,
    mbus.mem_addr, mbus.mem_wdata, sp_dec, sp_inc,
    pc_load, pc_load_value, flags_load, flags_value,
    hw_int_active, stall, flush, irq_ack, busy};

  // Memory, write log and SP register model
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (mbus.mem_req && mbus.mem_we && mbus.mem_gnt) begin
      mem[mbus.mem_addr[7:0]] <= mbus.mem_wdata;
      wr_addr[wn[5:0]] <= mbus.mem_addr;
      wr_data[wn[5:0]] <= mbus.mem_wdata;
      wn <= wn + 1;
    end
    if (sp_set) sp <= sp_val;
    else if (sp_dec) sp <= sp - 32'd1;
    else if (sp_inc) sp <= sp + 32'd1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a,
                      input logic [31:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task automatic set_sp(input logic [31:0] v);
    sp_val = v;
    sp_set = 1'b1;
    step();
    sp_set = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) step();
    chk(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int wb;
    logic [31:0] a0;
    logic [31:0] d0;
    rst       = 1'b1;
    irq       = 1'b0;
    rti_start = 1'b0;
    pc_in     = 32'h40;
    flags_in  = 4'b1010;
    gnt_en    = 1'b1;
    sp        = 32'h0;
    sp_val    = 32'h0;
    poke_a    = 8'h0;
    poke_d    = 32'h0;
    step();
    step();
    rst = 1'b0;
    chk("reset_outs", outs_or, 0);

    set_sp(32'hFF);
    poke(8'h01, 32'h200);

    // Interrupt entry
    wb  = wn;
    irq = 1'b1;
    step();
    n = 1;
    chk("drain", {hw_int_active, stall,
      mbus.mem_req, busy}, 4'b1101);
    while (!pc_load && n < 20) begin
      step();
      n++;
    end
    chk("irq_lat", n, 6);
    chk("vec_rd", {mbus.mem_we, mbus.mem_addr},
      {1'b0, 32'h1});
    chk("vec_load", {irq_ack, pc_load_value},
      {1'b1, 32'h200});
    irq = 1'b0;
    step();
    chk("done", {flush, stall, busy, pc_load},
      4'b1010);
    step();
    chk("idle", {busy, flush}, 0);
    chk("push_pc", {wr_addr[wb], wr_data[wb]},
      {32'hFF, 32'h40});
    chk("push_fl", {wr_addr[wb+1], wr_data[wb+1]},
      {32'hFE, 32'h0000000A});
    chk("sp_ent", sp, 32'hFD);

    // RTI
    rti_start = 1'b1;
    step();
    rti_start = 1'b0;
    chk("pop_fl", {flags_load, sp_inc, flags_value,
      mbus.mem_addr, hw_int_active},
      {1'b1, 1'b1, 4'hA, 32'hFE, 1'b0});
    step();
    chk("pop_pc", {pc_load, sp_inc, pc_load_value,
      mbus.mem_addr}, {1'b1, 1'b1, 32'h40, 32'hFF});
    step();
    chk("rti_flush", {flush, busy}, 2'b11);
    step();
    chk("sp_rti", sp, 32'hFF);

    // Grant stall in PUSH_PC
    gnt_en = 1'b0;
    pc_in  = 32'h1234;
    irq    = 1'b1;
    n = 0;
    while (!mbus.mem_req && n < 10) begin
      step();
      n++;
    end
    irq = 1'b0;
    chk("gs_req", {mbus.mem_req, mbus.mem_we},
      2'b11);
    a0 = mbus.mem_addr;
    d0 = mbus.mem_wdata;
    chk("gs_first", {a0, d0}, {32'hFF, 32'h1234});
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gs_hold", {sp_dec, mbus.mem_addr,
        mbus.mem_wdata}, {1'b0, 32'hFF, 32'h1234});
    end
    gnt_en = 1'b1;
    #1;
    chk("gs_dec", sp_dec, 1);
    wait_idle("gs_idle");
    chk("sp_gs", sp, 32'hFD);

    // Simultaneous irq and rti_start
    irq       = 1'b1;
    rti_start = 1'b1;
    step();
    rti_start = 1'b0;
    chk("sim_rti", {flags_load, hw_int_active,
      flags_value}, {1'b1, 1'b0, 4'hA});
    step();
    chk("sim_pc", {pc_load, pc_load_value},
      {1'b1, 32'h1234});
    step();
    chk("sim_done", flush, 1);
    step();
    chk("sim_idle", {busy, hw_int_active}, 0);
    step();
    chk("sim_irq", {hw_int_active, busy}, 2'b11);
    irq = 1'b0;
    wait_idle("sim_end");

    // Reset in PUSH_FL
    irq = 1'b1;
    n = 0;
    while (!sp_dec && n < 10) begin
      step();
      n++;
    end
    step();
    chk("rs_pushfl", {mbus.mem_req, mbus.mem_we,
      mbus.mem_wdata}, {2'b11, 32'hA});
    rst = 1'b1;
    #1;
    chk("rs_nopulse", sp_dec, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rs_outs", outs_or, 0);
    step();
    chk("rs_drain", {hw_int_active, mbus.mem_req},
      2'b10);
    irq = 1'b0;
    wait_idle("rs_end");

    // Address wrap on pop
    set_sp(32'hFFFFFFFF);
    poke(8'h00, 32'h5);
    poke(8'h01, 32'h77);
    rti_start = 1'b1;
    step();
    rti_start = 1'b0;
    chk("wr_fl", {mbus.mem_addr, flags_value},
      {32'h0, 4'h5});
    step();
    chk("wr_pc", {mbus.mem_addr, pc_load_value},
      {32'h1, 32'h77});
    step();
    chk("wr_done", flush, 1);
    wait_idle("wr_end");

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
